// File: rtl/monoc_pkg.sv
// monoc_pkg: shared image/grid constants, FSM state enum and read-tag type for the grid scanner.
// Contents: default image and cell geometry, CNT_W, state_t {IDLE, SCAN, DRAIN, EMIT, DONE},
// tag_t {valid, col[3:0]}, and cnt_width() for sizing per-cell counters.
package monoc_pkg;
    localparam int IMG_W_D     = 400;
    localparam int IMG_H_D     = 240;
    localparam int CELL_W_D    = 40;
    localparam int CELL_H_D    = 24;
    localparam int GRID_COLS_D = IMG_W_D / CELL_W_D;
    localparam int GRID_ROWS_D = IMG_H_D / CELL_H_D;
    localparam int MAP_W_D     = GRID_COLS_D * GRID_ROWS_D;
    localparam int CNT_W       = $clog2(CELL_W_D * CELL_H_D + 1);
    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, EMIT, DONE} state_t;
    typedef struct packed {
        logic       valid;
        logic [3:0] col;
    } tag_t;
    function automatic int cnt_width(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction
endpackage

// File: rtl/monoc_grid_scanner_if.sv
// monoc_grid_scanner_if: bundles the scanner's control, buffer read port and result signals.
// master = scanner side (drives reads and results), slave = buffer/board-logic side.
// Signals: start, busy, done, rd_en, rd_addr, rd_data, cell_valid, cell_col, cell_row,
// cell_count, cell_occ, occ_map.
interface monoc_grid_scanner_if
    import monoc_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int CNT_W  = monoc_pkg::CNT_W,
    parameter int MAP_W  = MAP_W_D
);
    logic              start;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_data;
    logic              cell_valid;
    logic [3:0]        cell_col;
    logic [3:0]        cell_row;
    logic [CNT_W-1:0]  cell_count;
    logic              cell_occ;
    logic [MAP_W-1:0]  occ_map;
    modport master (
        input  start, rd_data,
        output busy, done, rd_en, rd_addr, cell_valid, cell_col, cell_row, cell_count, cell_occ, occ_map
    );
    modport slave (
        output start, rd_data,
        input  busy, done, rd_en, rd_addr, cell_valid, cell_col, cell_row, cell_count, cell_occ, occ_map
    );
endinterface

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: RD_LAT-deep shift register that carries each read's tag until its data returns.
// Ports: clk, rst_n (async, active low, flushes all stages), tag_in (tag of the read issued
// this cycle), tag_out (tag belonging to the rd_data present this cycle).
module rd_tag_pipe
    import monoc_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_out
);
    tag_t pipe [RD_LAT];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign tag_out = pipe[RD_LAT-1];
endmodule

// File: rtl/monoc_grid_scanner.sv
// monoc_grid_scanner: scans the 1-bit frame buffer band by band and reports set-pixel counts
// and occupancy per grid cell, plus an occupancy map registered at the end of each scan.
// Ports: clk, rst_n (async, active low), bus (master modport: start/busy/done control,
// rd_en/rd_addr/rd_data buffer read port, cell_valid/cell_col/cell_row/cell_count/cell_occ
// per-cell results, occ_map with bit row*GRID_COLS+col).
module monoc_grid_scanner
    import monoc_pkg::*;
#(
    parameter int IMG_W      = 400,
    parameter int IMG_H      = 240,
    parameter int ADDR_W     = 17,
    parameter int RD_LAT     = 2,
    parameter int CELL_W     = 40,
    parameter int CELL_H     = 24,
    parameter int OCC_THRESH = 240
) (
    input logic                  clk,
    input logic                  rst_n,
    monoc_grid_scanner_if.master bus
);
    localparam int GRID_COLS = IMG_W / CELL_W;
    localparam int GRID_ROWS = IMG_H / CELL_H;
    localparam int MAP_W     = GRID_COLS * GRID_ROWS;
    localparam int CW        = cnt_width(CELL_W, CELL_H);
    localparam int X_W       = $clog2(IMG_W + 1);
    localparam int CX_W      = $clog2(CELL_W + 1);
    localparam int Y_W       = $clog2(CELL_H + 1);
    localparam int MI_W      = $clog2(MAP_W);
    localparam logic [2:0] ST_IDLE  = 3'(IDLE);
    localparam logic [2:0] ST_SCAN  = 3'(SCAN);
    localparam logic [2:0] ST_DRAIN = 3'(DRAIN);
    localparam logic [2:0] ST_EMIT  = 3'(EMIT);
    localparam logic [2:0] ST_DONE  = 3'(DONE);

    logic [2:0]        state, state_nx;
    logic [ADDR_W-1:0] addr;
    logic [X_W-1:0]    x;
    logic [CX_W-1:0]   cx;
    logic [Y_W-1:0]    y;
    logic [3:0]        col, sub, brow;
    logic [CW-1:0]     acc [16];
    logic [CW-1:0]     cur;
    logic [MAP_W-1:0]  occ_shadow, occ_map;
    logic [MI_W-1:0]   map_idx;
    logic              scan, drain, emit, fin, occ;
    logic              x_last, cx_last, band_end, drain_end, emit_end, last_band;
    tag_t              tag_in, tag_out;

    assign scan      = state == ST_SCAN;
    assign drain     = state == ST_DRAIN;
    assign emit      = state == ST_EMIT;
    assign fin       = state == ST_DONE;
    assign x_last    = x == X_W'(IMG_W - 1);
    assign cx_last   = cx == CX_W'(CELL_W - 1);
    assign band_end  = x_last && y == Y_W'(CELL_H - 1);
    assign drain_end = sub == 4'(RD_LAT - 1);
    assign emit_end  = sub == 4'(GRID_COLS - 1);
    assign last_band = brow == 4'(GRID_ROWS - 1);
    assign cur       = acc[sub];
    assign occ       = cur >= CW'(OCC_THRESH);
    assign map_idx   = MI_W'(brow) * MI_W'(GRID_COLS) + MI_W'(sub);
    assign tag_in    = '{valid: scan, col: col};

    always_comb begin
        state_nx = state == ST_IDLE ? (bus.start ? ST_SCAN : ST_IDLE) :
                   scan             ? (band_end ? ST_DRAIN : ST_SCAN) :
                   drain            ? (drain_end ? ST_EMIT : ST_DRAIN) :
                   emit             ? (emit_end ? (last_band ? ST_DONE : ST_SCAN) : ST_EMIT) :
                                      ST_IDLE;
    end

    rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // x wraps per image row, cx per cell width; both land on 0 at every band boundary,
    // so the next band starts with col 0 without explicit reloading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            addr       <= '0;
            x          <= '0;
            cx         <= '0;
            y          <= '0;
            col        <= '0;
            sub        <= '0;
            brow       <= '0;
            occ_shadow <= '0;
            occ_map    <= '0;
        end else begin
            state <= state_nx;
            addr  <= scan ? addr + ADDR_W'(1) : fin ? '0 : addr;
            sub   <= ((drain && !drain_end) || (emit && !emit_end)) ? sub + 4'd1 : '0;
            if (scan) begin
                x   <= x_last ? '0 : x + X_W'(1);
                cx  <= (x_last || cx_last) ? '0 : cx + CX_W'(1);
                col <= x_last ? '0 : cx_last ? col + 4'd1 : col;
                if (x_last) y <= y == Y_W'(CELL_H - 1) ? '0 : y + Y_W'(1);
            end
            if (emit && emit_end) brow <= last_band ? '0 : brow + 4'd1;
            if (emit && occ) occ_shadow[map_idx] <= 1'b1;
            else if (fin) occ_shadow <= '0;
            if (fin) occ_map <= occ_shadow;
        end
    end

    // Tags only return during SCAN/DRAIN, so an accumulator is never incremented and
    // cleared in the same cycle; entries at or beyond GRID_COLS stay constant zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) acc[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (emit && sub == 4'(i)) acc[i] <= '0;
                else if (tag_out.valid && tag_out.col == 4'(i) && bus.rd_data) acc[i] <= acc[i] + CW'(1);
            end
        end
    end

    assign bus.busy       = state != ST_IDLE;
    assign bus.done       = fin;
    assign bus.rd_en      = scan;
    assign bus.rd_addr    = scan ? addr : '0;
    assign bus.cell_valid = emit;
    assign bus.cell_col   = emit ? sub : '0;
    assign bus.cell_row   = emit ? brow : '0;
    assign bus.cell_count = emit ? cur : '0;
    assign bus.cell_occ   = emit && occ;
    assign bus.occ_map    = occ_map;
endmodule
